joystick_adc_spi: RTL

SPI master that reads the two joystick axes from an MCP3002-class 2-channel, 10-bit ADC and presents them as registered X/Y words. It sits directly downstream of the clock divider in the joystick datapath. It consumes the divider's square-wave output as a bit-rate reference, not as a clock: the block synchronises that signal into its own clock domain. The resulting X/Y words feed the game logic.

---
 rtl/joystick_adc_spi.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/joystick_adc_spi.sv
// SPI master for an MCP3002-class 2-channel 10-bit ADC: alternately converts channel 0 (X)
// and channel 1 (Y), paced by ticks derived from the clock divider's square wave.
module joystick_adc_spi #(
   parameter int GAP_TICKS = 2
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       clk_div,
   input  logic       en,
   input  logic       miso,
   output logic       cs_n,
   output logic       sck,
   output logic       mosi,
   output logic [9:0] x_val,
   output logic [9:0] y_val,
   output logic       xy_valid,
   output logic       busy
);

   localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t           state;
   logic             clk_div_p0, clk_div_p1, clk_div_p2;
   logic             tick;
   logic [4:0]       half_cnt;
   logic [4:0]       half_nxt;
   logic [GAP_W-1:0] gap_cnt;
   logic             ch;
   logic             sample;
   logic [9:0]       shift_p0;

   // Start, single-ended, channel select, MSB-first; the rest of the frame is don't-care (0).
   function automatic logic cmd_bit(input logic [3:0] bit_idx, input logic ch_sel);
      case (bit_idx)
         4'd0, 4'd1, 4'd3: cmd_bit = 1'b1;
         4'd2:             cmd_bit = ch_sel;
         default:          cmd_bit = 1'b0;
      endcase
   endfunction

   // Stage p0/p1: synchroniser; p2: edge register
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         clk_div_p0 <= 1'b0;
         clk_div_p1 <= 1'b0;
         clk_div_p2 <= 1'b0;
      end else begin
         clk_div_p0 <= clk_div;
         clk_div_p1 <= clk_div_p0;
         clk_div_p2 <= clk_div_p1;
      end
   end

   assign tick     = clk_div_p1 & ~clk_div_p2;
   assign half_nxt = half_cnt + 5'd1;

   // Only SPI bits 5..14 (D9..D0) are captured, on the sck-rising step of each bit.
   assign sample = tick && (state == SHIFT) && !half_cnt[0] &&
                   (half_cnt[4:1] >= 4'd5) && (half_cnt[4:1] <= 4'd14);

   always_ff @(posedge clk_in) begin
      if (sample)
         shift_p0 <= {shift_p0[8:0], miso};
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cs_n     <= 1'b1;
         sck      <= 1'b0;
         mosi     <= 1'b0;
         x_val    <= '0;
         y_val    <= '0;
         xy_valid <= 1'b0;
         busy     <= 1'b0;
         ch       <= 1'b0;
         half_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         xy_valid <= 1'b0;
         if (tick) begin
            case (state)
               IDLE: begin
                  if (en) begin
                     state <= SETUP;
                     cs_n  <= 1'b0;
                     busy  <= 1'b1;
                     mosi  <= cmd_bit(4'd0, ch);
                  end
               end
               SETUP: begin
                  state    <= SHIFT;
                  half_cnt <= '0;
               end
               SHIFT: begin
                  if (half_cnt == 5'd31) begin
                     state <= HOLD;
                     sck   <= 1'b0;
                     mosi  <= 1'b0;
                     if (ch) begin
                        y_val    <= shift_p0;
                        xy_valid <= 1'b1;
                     end else begin
                        x_val <= shift_p0;
                     end
                  end else begin
                     half_cnt <= half_nxt;
                     sck      <= half_nxt[0];
                     if (!half_nxt[0])
                        mosi <= cmd_bit(half_nxt[4:1], ch);
                  end
               end
               HOLD: begin
                  state   <= GAP;
                  cs_n    <= 1'b1;
                  gap_cnt <= '0;
                  ch      <= ~ch;
               end
               GAP: begin
                  if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
                     if (en) begin
                        state <= SETUP;
                        cs_n  <= 1'b0;
                        mosi  <= cmd_bit(4'd0, ch);
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     gap_cnt <= gap_cnt + GAP_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
